// File: rtl/instr_sram_pkg.sv
// Shared encodings for the instruction SRAM controller: work states and the
// fixed margin settings driven onto the SRAM macro.
package instr_sram_pkg;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'b00,
      ST_WORK   = 2'b01,
      ST_PAUSE  = 2'b10,
      ST_FINISH = 2'b11
   } state_e;

   localparam logic [2:0] EMA_DEF  = 3'b011;
   localparam logic [1:0] EMAW_DEF = 2'b01;

endpackage

// File: rtl/sram_sp_model.sv
// Behavioural single-port SRAM with the production macro pin order; the hard
// macro replaces it in synthesis. Q holds its last read value while CEN=1.
module sram_sp_model #(
   parameter int WIDTH = 64,
   parameter int AW    = 9,
   parameter int WORDS = 512
) (
   output logic [WIDTH-1:0] Q,
   input  logic             CLK,
   input  logic             CEN,
   input  logic             GWEN,
   input  logic [AW-1:0]    A,
   input  logic [WIDTH-1:0] D,
   input  logic             STOV,
   input  logic [2:0]       EMA,
   input  logic [1:0]       EMAW,
   input  logic             EMAS,
   input  logic             RET1N,
   input  logic             WABL,
   input  logic             WABLM
);

   logic [WIDTH-1:0] mem_q [WORDS];

   // Timing-margin pins only matter on silicon.
   logic unused_margin;
   assign unused_margin = ^{STOV, EMA, EMAW, EMAS, RET1N, WABL, WABLM};

   always_ff @(posedge CLK) begin
      if (!CEN) begin
         if (!GWEN) begin
            mem_q[A] <= D;
         end else begin
            Q <= mem_q[A];
         end
      end
   end

endmodule

// File: rtl/instr_sram_ctrl.sv
// Instruction SRAM controller: sequential program load, random-access fetch,
// LOAD/WORK/PAUSE/FINISH tracking. INSTR_SRAM_PARITY_EN adds a stored parity bit.
//
// state     | meaning
// ST_LOAD   | accepting program words at sequential addresses
// ST_WORK   | serving fetches by pointer
// ST_PAUSE  | fetches held off, pending response still delivered
// ST_FINISH | idle until restart_i returns to LOAD
module instr_sram_ctrl
   import instr_sram_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   input  logic              rd_req_valid,
   output logic              rd_req_ready,
   input  logic [ADDR_W-1:0] rd_ptr,
   output logic              rd_rsp_valid,
   input  logic              rd_rsp_ready,
   output logic [DATA_W-1:0] rd_rsp_data,
   output logic              rd_err,
   output logic              rd_perr,
   input  logic              pause_i,
   input  logic              finish_i,
   input  logic              restart_i,
   output logic [1:0]        state,
   output logic [ADDR_W:0]   instr_count,
   output logic              overflow
);

`ifdef INSTR_SRAM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   instr_count_q, instr_count_d;
   logic              overflow_q, overflow_d;
   logic              wr_ready_q, wr_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rd_err_q, rd_err_d;

   logic              wr_fire, rd_fire, rd_in_range, rsp_keep;
   logic              cen, gwen;
   logic [ADDR_W-1:0] mem_a;
   logic [MEM_W-1:0]  mem_d, mem_q;

   assign wr_fire      = wr_valid && wr_ready_q;
   assign rd_req_ready = (state_q == ST_WORK) && (!rsp_valid_q || rd_rsp_ready);
   assign rd_fire      = rd_req_valid && rd_req_ready;
   assign rd_in_range  = {1'b0, rd_ptr} < instr_count_q;

   always_comb begin
      state_d       = state_q;
      instr_count_d = instr_count_q;
      overflow_d    = overflow_q;
      case (state_q)
         ST_LOAD: begin
            if (wr_fire) begin
               instr_count_d = instr_count_q + 1'b1;
               if (wr_last) begin
                  state_d = ST_WORK;
               end else if (instr_count_q + 1'b1 == DEPTH_C) begin
                  overflow_d = 1'b1;
                  state_d    = ST_WORK;
               end
            end
         end
         ST_WORK: begin
            if (finish_i) begin
               state_d = ST_FINISH;
            end else if (pause_i) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (finish_i) begin
               state_d = ST_FINISH;
            end else if (!pause_i) begin
               state_d = ST_WORK;
            end
         end
         ST_FINISH: begin
            if (restart_i) begin
               state_d       = ST_LOAD;
               instr_count_d = '0;
               overflow_d    = 1'b0;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // A response survives only a WORK<->PAUSE move; any other exit discards it.
   always_comb begin
      rsp_keep = (state_d == state_q) ||
                 ((state_q inside {ST_WORK, ST_PAUSE}) && (state_d inside {ST_WORK, ST_PAUSE}));
      rsp_valid_d = rsp_valid_q;
      if (rsp_valid_q && rd_rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      if (rd_fire && rd_in_range) begin
         rsp_valid_d = 1'b1;
      end
      if (!rsp_keep) begin
         rsp_valid_d = 1'b0;
      end
      rd_err_d   = rd_fire && !rd_in_range;
      wr_ready_d = (state_d == ST_LOAD) && (instr_count_d < DEPTH_C);
   end

   always_comb begin
      cen   = 1'b1;
      gwen  = 1'b1;
      mem_a = '0;
      mem_d = '0;
      if (wr_fire) begin
         cen   = 1'b0;
         gwen  = 1'b0;
         mem_a = instr_count_q[ADDR_W-1:0];
`ifdef INSTR_SRAM_PARITY_EN
         mem_d = {^wr_data, wr_data};
`else
         mem_d = wr_data;
`endif
      end else if (rd_fire && rd_in_range) begin
         cen   = 1'b0;
         mem_a = rd_ptr;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_LOAD;
         instr_count_q <= '0;
         overflow_q    <= 1'b0;
         wr_ready_q    <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rd_err_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_count_q <= instr_count_d;
         overflow_q    <= overflow_d;
         wr_ready_q    <= wr_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rd_err_q      <= rd_err_d;
      end
   end

   sram_sp_model #(
      .WIDTH (MEM_W),
      .AW    (ADDR_W),
      .WORDS (DEPTH)
   ) u_mem (
      .Q     (mem_q),
      .CLK   (CLK),
      .CEN   (cen),
      .GWEN  (gwen),
      .A     (mem_a),
      .D     (mem_d),
      .STOV  (1'b0),
      .EMA   (EMA_DEF),
      .EMAW  (EMAW_DEF),
      .EMAS  (1'b0),
      .RET1N (1'b1),
      .WABL  (1'b0),
      .WABLM (1'b0)
   );

   // The macro has no reset, so data is forced to zero whenever nothing is presented.
   assign rd_rsp_data  = rsp_valid_q ? mem_q[DATA_W-1:0] : '0;
   assign rd_rsp_valid = rsp_valid_q;
   assign rd_err       = rd_err_q;
   assign wr_ready     = wr_ready_q;
   assign state        = state_q;
   assign instr_count  = instr_count_q;
   assign overflow     = overflow_q;

`ifdef INSTR_SRAM_PARITY_EN
   assign rd_perr = rsp_valid_q && (^mem_q);
`else
   assign rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sram_ctrl.sv
// Randomized bench for instr_sram_ctrl against a transaction-level model of
// the program store, the single response slot and the work state.
module tb_instr_sram_ctrl;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 24;
   localparam int PTR_MAX = (1 << ADDR_W) - 1;
   localparam int M_LOAD = 0, M_WORK = 1, M_PAUSE = 2, M_FINISH = 3;

   logic              CLK = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr_valid = 1'b0, wr_last = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_ready;
   logic              rd_req_valid = 1'b0, rd_rsp_ready = 1'b1;
   logic [ADDR_W-1:0] rd_ptr = '0;
   logic              rd_req_ready, rd_rsp_valid, rd_err, rd_perr;
   logic [DATA_W-1:0] rd_rsp_data;
   logic              pause_i = 1'b0, finish_i = 1'b0, restart_i = 1'b0;
   logic [1:0]        state;
   logic [ADDR_W:0]   instr_count;
   logic              overflow;

   int n_chk = 0;
   int n_fail = 0;

   logic [63:0] mem_m [DEPTH];
   int          cnt_m = 0;
   int          st_m  = M_LOAD;
   bit          ovf_m = 0;

   instr_sram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .CLK          (CLK),
      .rst_n        (rst_n),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .wr_last      (wr_last),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rd_req_ready),
      .rd_ptr       (rd_ptr),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_ready (rd_rsp_ready),
      .rd_rsp_data  (rd_rsp_data),
      .rd_err       (rd_err),
      .rd_perr      (rd_perr),
      .pause_i      (pause_i),
      .finish_i     (finish_i),
      .restart_i    (restart_i),
      .state        (state),
      .instr_count  (instr_count),
      .overflow     (overflow)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_status(input string tag);
      chk({tag, ".state"}, 64'(state), 64'(st_m));
      chk({tag, ".count"}, 64'(instr_count), 64'(cnt_m));
      chk({tag, ".overflow"}, 64'(overflow), 64'(ovf_m));
   endtask

   task automatic load_word(input logic [63:0] d, input bit last);
      wr_valid = 1'b1;
      wr_data  = d;
      wr_last  = last;
      #1;
      chk("wr_ready", 64'(wr_ready), 64'((st_m == M_LOAD) && (cnt_m < DEPTH)));
      step();
      mem_m[cnt_m] = d;
      cnt_m++;
      if (last) begin
         st_m = M_WORK;
      end else if (cnt_m == DEPTH) begin
         ovf_m = 1;
         st_m  = M_WORK;
      end
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      chk_status("load");
   endtask

   task automatic load_prog(input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            wr_valid = 1'b0;
            wr_data  = {$urandom, $urandom};
            step();
            chk("idle_count", 64'(instr_count), 64'(cnt_m));
         end
         load_word({$urandom, $urandom}, with_last && (i == n - 1));
      end
   endtask

   task automatic fetch1(input int ptr);
      rd_rsp_ready = 1'b1;
      rd_req_valid = 1'b1;
      rd_ptr       = ADDR_W'(ptr);
      #1;
      chk("fetch.req_ready", 64'(rd_req_ready), 64'd1);
      step();
      rd_req_valid = 1'b0;
      if (ptr < cnt_m) begin
         chk("fetch.rsp_valid", 64'(rd_rsp_valid), 64'd1);
         chk("fetch.data", rd_rsp_data, mem_m[ptr]);
         chk("fetch.err", 64'(rd_err), 64'd0);
      end else begin
         chk("fetch.rsp_valid", 64'(rd_rsp_valid), 64'd0);
         chk("fetch.err", 64'(rd_err), 64'd1);
      end
      step();
      chk("fetch.after_valid", 64'(rd_rsp_valid), 64'd0);
      chk("fetch.after_err", 64'(rd_err), 64'd0);
   endtask

   // Cycle-level traffic against a single pending-response slot.
   task automatic work_traffic(input int n);
      bit          pend = 0;
      bit          err_exp, rdy_exp, fire;
      logic [63:0] pdata = '0;
      for (int i = 0; i < n; i++) begin
         rd_req_valid = 1'($urandom_range(0, 1));
         rd_ptr       = ADDR_W'($urandom_range(0, PTR_MAX));
         rd_rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         rdy_exp = !pend || rd_rsp_ready;
         chk("trf.req_ready", 64'(rd_req_ready), 64'(rdy_exp));
         fire = rd_req_valid && rdy_exp;
         if (pend && rd_rsp_ready) pend = 0;
         err_exp = 0;
         if (fire) begin
            if (int'(rd_ptr) < cnt_m) begin
               pend  = 1;
               pdata = mem_m[rd_ptr];
            end else begin
               err_exp = 1;
            end
         end
         step();
         chk("trf.rsp_valid", 64'(rd_rsp_valid), 64'(pend));
         chk("trf.data", rd_rsp_data, pend ? pdata : 64'd0);
         chk("trf.err", 64'(rd_err), 64'(err_exp));
         chk("trf.perr", 64'(rd_perr), 64'd0);
      end
      rd_req_valid = 1'b0;
      rd_rsp_ready = 1'b1;
      step();
      chk("trf.drain", 64'(rd_rsp_valid), 64'd0);
   endtask

   task automatic finish_restart(input bit with_pause);
      pause_i  = with_pause;
      finish_i = 1'b1;
      step();
      st_m = M_FINISH;
      pause_i  = 1'b0;
      finish_i = 1'b0;
      chk_status("finish");
      rd_req_valid = 1'b1;
      #1;
      chk("finish.req_ready", 64'(rd_req_ready), 64'd0);
      rd_req_valid = 1'b0;
      step();
      restart_i = 1'b1;
      step();
      restart_i = 1'b0;
      st_m  = M_LOAD;
      cnt_m = 0;
      ovf_m = 0;
      chk_status("restart");
      chk("restart.wr_ready", 64'(wr_ready), 64'd1);
   endtask

   initial begin
      #23;
      chk("rst.state", 64'(state), 64'd0);
      chk("rst.count", 64'(instr_count), 64'd0);
      chk("rst.wr_ready", 64'(wr_ready), 64'd0);
      chk("rst.req_ready", 64'(rd_req_ready), 64'd0);
      chk("rst.rsp_valid", 64'(rd_rsp_valid), 64'd0);
      chk("rst.err", 64'(rd_err), 64'd0);
      chk("rst.overflow", 64'(overflow), 64'd0);
      chk("rst.data", rd_rsp_data, 64'd0);
      @(negedge CLK);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 4; i++) load_word(64'hA0 + 64'(i), i == 3);
      chk("prog4.state", 64'(state), 64'(M_WORK));
      chk("prog4.wr_ready", 64'(wr_ready), 64'd0);
      fetch1(2);
      fetch1(4);

      // Back-pressured response blocks a second request.
      rd_rsp_ready = 1'b0;
      rd_req_valid = 1'b1;
      rd_ptr       = 1;
      #1;
      chk("hold.first_ready", 64'(rd_req_ready), 64'd1);
      step();
      rd_ptr = 3;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold.req_ready", 64'(rd_req_ready), 64'd0);
         chk("hold.data", rd_rsp_data, 64'hA1);
         step();
      end
      rd_rsp_ready = 1'b1;
      #1;
      chk("hold.release_ready", 64'(rd_req_ready), 64'd1);
      step();
      rd_req_valid = 1'b0;
      chk("hold.next_valid", 64'(rd_rsp_valid), 64'd1);
      chk("hold.next_data", rd_rsp_data, 64'hA3);
      step();
      chk("hold.done", 64'(rd_rsp_valid), 64'd0);

      // Pending response is delivered across PAUSE.
      rd_rsp_ready = 1'b0;
      rd_req_valid = 1'b1;
      rd_ptr       = 0;
      step();
      rd_req_valid = 1'b0;
      pause_i      = 1'b1;
      step();
      st_m = M_PAUSE;
      chk_status("pause");
      chk("pause.rsp_valid", 64'(rd_rsp_valid), 64'd1);
      chk("pause.data", rd_rsp_data, 64'hA0);
      rd_req_valid = 1'b1;
      rd_rsp_ready = 1'b1;
      #1;
      chk("pause.req_ready", 64'(rd_req_ready), 64'd0);
      step();
      rd_req_valid = 1'b0;
      chk("pause.delivered", 64'(rd_rsp_valid), 64'd0);
      pause_i = 1'b0;
      step();
      st_m = M_WORK;
      chk_status("unpause");

      restart_i = 1'b1;
      step();
      restart_i = 1'b0;
      chk_status("restart_ignored");

      work_traffic(150);
      finish_restart(1'b1);

      load_prog(DEPTH, 1'b0);
      chk("ovf.wr_ready", 64'(wr_ready), 64'd0);
      step();
      chk_status("ovf.settled");
      fetch1(DEPTH - 1);
      fetch1(DEPTH);
      work_traffic(150);
      finish_restart(1'b0);

      load_prog($urandom_range(1, DEPTH - 1), 1'b1);
      work_traffic(150);

`ifdef INSTR_SRAM_PARITY_EN
      dut.u_mem.mem_q[0][0] = ~dut.u_mem.mem_q[0][0];
      rd_req_valid = 1'b1;
      rd_ptr       = 0;
      step();
      rd_req_valid = 1'b0;
      chk("parity.rsp_valid", 64'(rd_rsp_valid), 64'd1);
      chk("parity.perr", 64'(rd_perr), 64'd1);
      step();
`endif

      // Asynchronous reset with a response outstanding.
      rd_rsp_ready = 1'b0;
      rd_req_valid = 1'b1;
      rd_ptr       = 0;
      step();
      rd_req_valid = 1'b0;
      chk("midrst.pending", 64'(rd_rsp_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst.rsp_valid", 64'(rd_rsp_valid), 64'd0);
      chk("midrst.data", rd_rsp_data, 64'd0);
      chk("midrst.state", 64'(state), 64'd0);
      chk("midrst.count", 64'(instr_count), 64'd0);
      chk("midrst.wr_ready", 64'(wr_ready), 64'd0);
      @(negedge CLK);
      rst_n = 1'b1;
      rd_rsp_ready = 1'b1;
      step();
      chk("midrst.wr_ready_after", 64'(wr_ready), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instr_sram_ctrl.md
Name: instr_sram_ctrl

Overview:
Parametrised controller for a single-port instruction SRAM macro; successor to the fixed 512x64 instruction-memory peripheral.
- Loads an instruction stream over a valid/ready write channel at sequential addresses.
- Serves random-access fetches by pointer over a request/response channel.
- Tracks the LOAD/WORK/PAUSE/FINISH work state.
- Sits between the host loader and the CPU fetch stage.

Parameters:
DATA_W, 64, instruction word width
ADDR_W, 9, macro address width
DEPTH, 512, words used (<= 2**ADDR_W)

Ports:
CLK  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  load word valid
wr_ready  out  1  load word accepted when both high
wr_data  in  DATA_W  load word
wr_last  in  1  final word of program
rd_req_valid  in  1  fetch request
rd_req_ready  out  1  fetch accepted when both high
rd_ptr  in  ADDR_W  fetch address (read pointer, starts at 0)
rd_rsp_valid  out  1  fetch data valid
rd_rsp_ready  in  1  fetch data consumed
rd_rsp_data  out  DATA_W  fetched word
rd_err  out  1  1-cycle pulse: accepted rd_ptr >= instr_count
pause_i  in  1  request PAUSE
finish_i  in  1  request FINISH
restart_i  in  1  FINISH -> LOAD
state  out  2  00 LOAD, 01 WORK, 10 PAUSE, 11 FINISH
instr_count  out  ADDR_W+1  words loaded
overflow  out  1  sticky: load hit DEPTH before wr_last

Behaviour:
- Reset: rst_n is asynchronous, active-low; CLK is the clock. Reset values: state=LOAD, instr_count=0, wr_ready=0, rd_req_ready=0, rd_rsp_valid=0, rd_err=0, overflow=0, rd_rsp_data=0.
- Macro drive: CEN and GWEN are active-low; GWEN=0 is a write. Margin pins are constants: STOV=0, EMA=3'b011, EMAW=2'b01, EMAS=0, RET1N=1, WABL=0, WABLM=0.
- At most one macro access per cycle. When idle, CEN=1.
- LOAD:
  - wr_ready = (instr_count < DEPTH).
  - On accept: CEN=0, GWEN=0, A=instr_count, D=wr_data; instr_count increments.
  - wr_last accepted -> WORK on the next cycle.
  - instr_count reaching DEPTH without wr_last: overflow=1, then -> WORK.
  - Fetch requests are not accepted (rd_req_ready=0).
- WORK:
  - rd_req_ready = !rd_rsp_valid || rd_rsp_ready.
  - Accept with rd_ptr < instr_count: CEN=0, GWEN=1, A=rd_ptr. The next cycle gives rd_rsp_valid=1 and rd_rsp_data=Q. Latency is 1.
  - Response holds until rd_rsp_ready. The macro retains Q while CEN=1.
  - Back-to-back accepts under continuous rd_rsp_ready give 1 word per cycle.
  - Accept with rd_ptr >= instr_count: no macro access, rd_err pulses, no response.
- PAUSE:
  - Entered from WORK on pause_i; returns to WORK when pause_i deasserts.
  - rd_req_ready=0. A pending response is still delivered.
- FINISH:
  - Entered on finish_i from WORK or PAUSE. finish_i wins over pause_i when both are asserted.
  - rd_req_ready=0.
  - restart_i -> LOAD with instr_count=0 and overflow cleared. Macro contents are not cleared.
  - restart_i outside FINISH is ignored.
- A pending response is dropped on any state exit except WORK<->PAUSE.
- Reset mid-load or mid-fetch returns to the reset values immediately. A partially issued write may be lost.

Optional Feature:
INSTR_SRAM_PARITY_EN
- Defined:
  - Macro width is DATA_W+1; the extra bit stores even parity of wr_data.
  - Adds output rd_perr, valid with rd_rsp_valid and 1 on a parity mismatch.
- Undefined: macro width is DATA_W and rd_perr is tied to 0.

Decomposition:
- Shared package (instr_sram_pkg):
  - State encodings ST_LOAD, ST_WORK, ST_PAUSE, ST_FINISH.
  - Macro margin constants: EMA_DEF, EMAW_DEF.
- Sub-module: sram_sp_model, a parametrised behavioural single-port macro.
  - Same pin order as the production macro.
  - Q held while CEN=1.
  - Swapped for the hard macro in synthesis.

Test Plan:
- Load 4 words 0xA0..0xA3 with wr_last on the 4th -> instr_count=4, state=WORK the cycle after.
- Fetch rd_ptr=2 -> rd_rsp_valid 1 cycle later, rd_rsp_data=0xA2. Then fetch rd_ptr=4 -> rd_err pulse, no rd_rsp_valid.
- Hold rd_rsp_ready=0 with a pending response and issue a 2nd request -> rd_req_ready=0 and data stable. Release -> next word follows one cycle after the handshake.
- Load DEPTH words without wr_last -> overflow=1, wr_ready=0, state=WORK.
- In WORK assert pause_i and finish_i together -> state=FINISH. Then restart_i -> LOAD, instr_count=0.
- With INSTR_SRAM_PARITY_EN, force-flip a stored bit in the model -> rd_perr=1 on that fetch.
